// File: rtl/hs_npu_act_feeder.sv
// Activation feeder: accepts one vector per cycle and drives the MAC array's left edge with diagonal skew.
// Optional per-batch handshake counter (vec_count_o) when HS_NPU_FEEDER_STATS_EN is defined.
module hs_npu_act_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N*DATA_W-1:0] in_data_i,
  input  logic                in_last_i,
  output logic [N*DATA_W-1:0] a_row_o,
  output logic [N-1:0]        a_valid_o,
  output logic                busy_o,
  output logic                done_o,
`ifdef HS_NPU_FEEDER_STATS_EN
  output logic [15:0]         vec_count_o,
`endif
  output logic [1:0]          dbg_state_o
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs;

  // Handshake: a vector transfers on a rising edge where in_valid_i and in_ready_o
  // are both high; in_data_i/in_last_i matter only then; in_ready_o never depends on in_valid_i.
  assign in_ready_o  = (state_q != S_FLUSH);
  assign hs          = in_valid_i & in_ready_o;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (hs) begin
          if (in_last_i) begin
            state_d = S_FLUSH;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        // Counter reaches zero exactly when the last element sits in row N-1's final stage.
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [DATA_W-1:0] d_q [0:r];
    logic [r:0]        v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int s = 0; s <= r; s++) d_q[s] <= '0;
      end else begin
        v_q[0] <= hs;
        d_q[0] <= hs ? in_data_i[r*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= r; s++) begin
          v_q[s] <= v_q[s-1];
          d_q[s] <= d_q[s-1];
        end
      end
    end

    assign a_row_o[r*DATA_W +: DATA_W] = d_q[r];
    assign a_valid_o[r]                = v_q[r];
  end

`ifdef HS_NPU_FEEDER_STATS_EN
  logic [15:0] vec_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q <= '0;
    end else if (done_o) begin
      vec_cnt_q <= '0;
    end else if (hs && (vec_cnt_q != 16'hFFFF)) begin
      vec_cnt_q <= vec_cnt_q + 16'd1;
    end
  end

  assign vec_count_o = vec_cnt_q;
`endif

endmodule

// File: tb/tb_hs_npu_act_feeder.sv
// Directed bench for hs_npu_act_feeder at N=4: skew timing, flush/done, bubbles, FLUSH back-pressure, mid-flush reset.
module tb_hs_npu_act_feeder;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [W-1:0] a_row;
  logic [N-1:0] a_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;
`ifdef HS_NPU_FEEDER_STATS_EN
  logic [15:0]  vec_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  bit           hist_v[$];
  logic [W-1:0] hist_d[$];

  hs_npu_act_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .a_row_o     (a_row),
    .a_valid_o   (a_valid),
    .busy_o      (busy),
    .done_o      (done),
`ifdef HS_NPU_FEEDER_STATS_EN
    .vec_count_o (vec_count),
`endif
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] vec4(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic drive(input logic v, input logic last, input logic [W-1:0] d);
    in_valid = v;
    in_last  = last;
    in_data  = d;
  endtask

  // Record what the coming edge injects, then advance to the following negedge.
  task automatic step();
    bit hs_now;
    hs_now = rst_n && in_valid && in_ready;
    hist_v.push_back(hs_now);
    hist_d.push_back(hs_now ? in_data : '0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Row i must show whatever was injected i edges before the latest one.
  task automatic check_skew();
    logic [W-1:0] ed;
    logic [N-1:0] ev;
    logic [W-1:0] hd;
    int h;
    int idx;
    ed = '0;
    ev = '0;
    h  = hist_v.size() - 1;
    for (int i = 0; i < N; i++) begin
      idx = h - i;
      if (idx >= 0 && hist_v[idx]) begin
        hd = hist_d[idx];
        ev[i] = 1'b1;
        ed[i*DW +: DW] = hd[i*DW +: DW];
      end
    end
    chk("skew_data", a_row, ed);
    chk("skew_valid", a_valid, ev);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_a_row", a_row, '0);
    chk("rst_a_valid", a_valid, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_a_valid", a_valid, '0);
    @(negedge clk);

    // Single vector {1,2,3,4} with last
    drive(1'b1, 1'b1, vec4(1, 2, 3, 4));
    for (int e = 0; e <= 4; e++) begin
      step();
      drive(1'b0, 1'b0, '0);
      check_skew();
      if (e < 4) begin
        chk("t2_valid", a_valid, 64'(1 << e));
        chk("t2_row", a_row, 64'(e + 1) << (e * DW));
        chk("t2_ready", in_ready, 0);
        chk("t2_state", dbg_state, 2);
      end
      chk("t2_done", done, (e == 3));
    end
    chk("t2_ready_back", in_ready, 1);
    chk("t2_busy_back", busy, 0);
    chk("t2_idle_valid", a_valid, '0);

    // Three consecutive vectors, last flagged on the third
    for (int e = 0; e <= 6; e++) begin
      if (e < 3) drive(1'b1, (e == 2), vec4(10*(e+1), 10*(e+1)+1, 10*(e+1)+2, 10*(e+1)+3));
      else       drive(1'b0, 1'b0, '0);
      step();
      check_skew();
      chk("t3_done", done, (e == 5));
      chk("t3_ready", in_ready, (e < 2 || e == 6));
      chk("t3_busy", busy, (e < 6));
`ifdef HS_NPU_FEEDER_STATS_EN
      chk("t3_vcnt", vec_count, (e < 2) ? e + 1 : ((e <= 5) ? 3 : 0));
`endif
      if (e == 2) begin
        chk("t3_e2_row", a_row, vec4(30, 21, 12, 0));
        chk("t3_e2_valid", a_valid, 4'b0111);
        chk("t3_e2_state", dbg_state, 2);
      end
      if (e == 5) chk("t3_e5_row3", a_row[3*DW +: DW], 33);
    end

    // Bubble between two vectors
    for (int e = 0; e <= 6; e++) begin
      if (e == 0)      drive(1'b1, 1'b0, vec4(40, 41, 42, 43));
      else if (e == 2) drive(1'b1, 1'b1, vec4(50, 51, 52, 53));
      else             drive(1'b0, 1'b0, '0);
      step();
      check_skew();
      chk("t4_done", done, (e == 5));
      if (e == 1) chk("t4_e1_state", dbg_state, 1);
      if (e == 2) begin
        chk("t4_e2_row", a_row, vec4(50, 0, 42, 0));
        chk("t4_e2_valid", a_valid, 4'b0101);
      end
      if (e == 3) begin
        chk("t4_e3_row", a_row, vec4(0, 51, 0, 43));
        chk("t4_e3_valid", a_valid, 4'b1010);
      end
    end

    // in_valid held with 0xBEEF through FLUSH
    for (int e = 0; e <= 9; e++) begin
      if (e == 0)      drive(1'b1, 1'b1, vec4(1, 2, 3, 4));
      else if (e <= 5) drive(1'b1, 1'b1, {N{16'hBEEF}});
      else             drive(1'b0, 1'b0, '0);
      step();
      check_skew();
      chk("t5_done", done, (e == 3 || e == 8));
      if (e >= 1 && e <= 4) chk("t5_no_beef_row0", a_valid[0], 0);
      if (e == 5) begin
        chk("t5_beef_row0", a_row[DW-1:0], 16'hBEEF);
        chk("t5_beef_valid", a_valid, 4'b0001);
      end
    end

    // Reset two cycles into FLUSH
    drive(1'b1, 1'b1, vec4(7, 8, 9, 10));
    step();
    drive(1'b0, 1'b0, '0);
    step();
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_a_row", a_row, '0);
    chk("t6_a_valid", a_valid, '0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_state", dbg_state, 0);
`ifdef HS_NPU_FEEDER_STATS_EN
    chk("t6_vcnt", vec_count, 0);
`endif
    hist_v.delete();
    hist_d.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    rst_n = 1'b1;
    step();
    check_skew();
    chk("t6_ready", in_ready, 1);
    chk("t6_busy_after", busy, 0);
    chk("t6_done_after", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
